dfii_init_sequencer: RTL and testbench

- Hardware DDR3 power-up/initialisation sequencer for the gram DFII.
- Acts as a Wishbone master on the DFII CSR bus and replays the JEDEC init sequence: reset release, CKE, MR2/MR3/MR1/MR0, tDLLK wait, ZQCL, tZQinit wait, then hands the PHY to hardware control.
- Replaces software-driven init; sits between the SoC CSR interconnect and the DFII control/command/address registers.

---
 rtl/dfii_init_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_dfii_init_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfii_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dfii_init_sequencer
// Purpose  : DDR3 power-up sequencer; Wishbone write master on the DFII CSRs.
//            Optional ack watchdog: define DFII_INIT_ACK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dfii_init_sequencer #(
  parameter logic [31:0] CSR_BASE = 32'h0000_2400,
  parameter logic [13:0] MR0_VAL  = 14'h220,
  parameter logic [13:0] MR1_VAL  = 14'h006,
  parameter logic [13:0] MR2_VAL  = 14'h200,
  parameter logic [13:0] MR3_VAL  = 14'h000,
  parameter logic [15:0] T_RST    = 16'd35,
  parameter logic [15:0] T_DLLK   = 16'd600,
  parameter logic [15:0] T_ZQINIT = 16'd600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_CMD   = 3'd1;
  localparam logic [2:0] REG_STB   = 3'd2;
  localparam logic [2:0] REG_ADDR  = 3'd3;
  localparam logic [2:0] REG_BADDR = 3'd4;

  localparam logic [31:0] CTRL_SW       = 32'h0000_0000;
  localparam logic [31:0] CTRL_RST_ODT  = 32'h0000_000C;
  localparam logic [31:0] CTRL_CKE      = 32'h0000_000E;
  localparam logic [31:0] CTRL_HW       = 32'h0000_0001;
  localparam logic [31:0] CMD_NONE      = 32'h0000_0000;
  localparam logic [31:0] CMD_MRS       = 32'h0000_000F;
  localparam logic [31:0] CMD_ZQCL      = 32'h0000_0003;
  localparam logic [31:0] STROBE_ONE    = 32'h0000_0001;
  localparam logic [31:0] ZQCL_ADDR     = 32'h0000_0400;
  localparam logic [13:0] MR0_DLL_RESET = 14'h100;

  localparam logic [5:0] LAST_STEP = 6'd32;

  typedef struct packed {
    logic        is_wait;
    logic [2:0]  reg_off;
    logic [31:0] data;
  } rom_entry_t;

  function automatic rom_entry_t wr(input logic [2:0] off, input logic [31:0] dat);
    return {1'b0, off, dat};
  endfunction

  function automatic rom_entry_t wt(input logic [15:0] len);
    return {1'b1, 3'd0, 16'd0, len};
  endfunction

  function automatic logic [31:0] mr(input logic [13:0] val);
    return {18'd0, val};
  endfunction

  // Each MRS is ADDRESS, BADDRESS, COMMAND, STROBE; waits carry their length in data.
  function automatic rom_entry_t rom_lookup(input logic [5:0] idx);
    case (idx)
      6'd0:    return wr(REG_CTRL,  CTRL_SW);
      6'd1:    return wr(REG_ADDR,  32'd0);
      6'd2:    return wr(REG_BADDR, 32'd0);
      6'd3:    return wr(REG_CMD,   CMD_NONE);
      6'd4:    return wr(REG_CTRL,  CTRL_RST_ODT);
      6'd5:    return wr(REG_CTRL,  CTRL_CKE);
      6'd6:    return wr(REG_ADDR,  mr(MR2_VAL));
      6'd7:    return wr(REG_BADDR, 32'd2);
      6'd8:    return wr(REG_CMD,   CMD_MRS);
      6'd9:    return wr(REG_STB,   STROBE_ONE);
      6'd10:   return wr(REG_ADDR,  mr(MR3_VAL));
      6'd11:   return wr(REG_BADDR, 32'd3);
      6'd12:   return wr(REG_CMD,   CMD_MRS);
      6'd13:   return wr(REG_STB,   STROBE_ONE);
      6'd14:   return wr(REG_ADDR,  mr(MR1_VAL));
      6'd15:   return wr(REG_BADDR, 32'd1);
      6'd16:   return wr(REG_CMD,   CMD_MRS);
      6'd17:   return wr(REG_STB,   STROBE_ONE);
      6'd18:   return wr(REG_ADDR,  mr(MR0_VAL | MR0_DLL_RESET));
      6'd19:   return wr(REG_BADDR, 32'd0);
      6'd20:   return wr(REG_CMD,   CMD_MRS);
      6'd21:   return wr(REG_STB,   STROBE_ONE);
      6'd22:   return wr(REG_ADDR,  mr(MR0_VAL));
      6'd23:   return wr(REG_BADDR, 32'd0);
      6'd24:   return wr(REG_CMD,   CMD_MRS);
      6'd25:   return wr(REG_STB,   STROBE_ONE);
      6'd26:   return wt(T_DLLK);
      6'd27:   return wr(REG_ADDR,  ZQCL_ADDR);
      6'd28:   return wr(REG_BADDR, 32'd0);
      6'd29:   return wr(REG_CMD,   CMD_ZQCL);
      6'd30:   return wr(REG_STB,   STROBE_ONE);
      6'd31:   return wt(T_ZQINIT);
      6'd32:   return wr(REG_CTRL,  CTRL_HW);
      default: return wr(REG_CTRL,  CTRL_SW);
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [5:0]  step_q,  step_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        cyc_q,   cyc_d;
  logic        stb_q,   stb_d;
  logic        we_q,    we_d;
  logic [3:0]  sel_q,   sel_d;
  logic [31:0] adr_q,   adr_d;
  logic [31:0] dat_q,   dat_d;
`ifdef DFII_INIT_ACK_TIMEOUT_EN
  // Counts 0..1022, so the watchdog fires on the 1023rd unacked ISSUE cycle.
  localparam logic [9:0] TMO_LIMIT = 10'd1022;
  logic        error_q, error_d;
  logic [9:0]  tmo_q,   tmo_d;
`endif

  logic [5:0]  rom_idx;
  rom_entry_t  rom;
  logic        issue;
  logic        release_bus;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    issue       = 1'b0;
    release_bus = 1'b0;
`ifdef DFII_INIT_ACK_TIMEOUT_EN
    error_d     = error_q;
    tmo_d       = tmo_q;
`endif
    // GAP looks one entry ahead; WAIT exits into the entry step already points at.
    rom_idx = (state_q == S_GAP) ? (step_q + 6'd1) : step_q;
    rom     = rom_lookup(rom_idx);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          step_d  = 6'd0;
          cnt_d   = T_RST;
          state_d = S_WAIT;
`ifdef DFII_INIT_ACK_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q <= 16'd1) begin
          issue   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_ISSUE: begin
        if (wb_ack) begin
          release_bus = 1'b1;
          state_d     = S_GAP;
        end
`ifdef DFII_INIT_ACK_TIMEOUT_EN
        else if (tmo_q == TMO_LIMIT) begin
          release_bus = 1'b1;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_ERROR;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
`endif
      end
      S_GAP: begin
        if (step_q == LAST_STEP) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (rom.is_wait) begin
          cnt_d   = rom.data[15:0];
          step_d  = step_q + 6'd2;
          state_d = S_WAIT;
        end else begin
          step_d  = step_q + 6'd1;
          issue   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = 1'b1;
      sel_d = 4'hF;
      adr_d = CSR_BASE + {29'd0, rom.reg_off};
      dat_d = rom.data;
`ifdef DFII_INIT_ACK_TIMEOUT_EN
      tmo_d = 10'd0;
`endif
    end
    if (release_bus) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d  = 1'b0;
      sel_d = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 6'd0;
      cnt_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

`ifdef DFII_INIT_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
      tmo_q   <= 10'd0;
    end else begin
      error_q <= error_d;
      tmo_q   <= tmo_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign wb_cyc   = cyc_q;
  assign wb_stb   = stb_q;
  assign wb_we    = we_q;
  assign wb_sel   = sel_q;
  assign wb_adr   = adr_q;
  assign wb_dat_w = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_dfii_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dfii_init_sequencer
// Purpose  : Scoreboard bench for dfii_init_sequencer (write log, waits, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dfii_init_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [31:0] wb_adr, wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we;
  logic        wb_ack;

  dfii_init_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .wb_adr   (wb_adr),
    .wb_dat_w (wb_dat_w),
    .wb_sel   (wb_sel),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_ack   (wb_ack)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] exp_q[$];
  int          wr_idx  = 0;
  time         t_rise [0:31];
  time         t_ack  [0:31];
  time         t_start;
  bit          slave_en = 1'b1;
  int          ack_max  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    else
      n_pass++;
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] dat);
    exp_q.push_back({adr, dat});
  endtask

  task automatic push_mrs(input logic [31:0] val, input logic [31:0] ba);
    push(32'h2403, val);
    push(32'h2404, ba);
    push(32'h2401, 32'h0F);
    push(32'h2402, 32'h01);
  endtask

  // Expected 31-write log, hand-derived from the init sequence.
  task automatic push_sequence();
    exp_q.delete();
    wr_idx = 0;
    push(32'h2400, 32'h00);
    push(32'h2403, 32'h00);
    push(32'h2404, 32'h00);
    push(32'h2401, 32'h00);
    push(32'h2400, 32'h0C);
    push(32'h2400, 32'h0E);
    push_mrs(32'h200, 32'd2);
    push_mrs(32'h000, 32'd3);
    push_mrs(32'h006, 32'd1);
    push_mrs(32'h320, 32'd0);
    push_mrs(32'h220, 32'd0);
    push(32'h2403, 32'h400);
    push(32'h2404, 32'h00);
    push(32'h2401, 32'h03);
    push(32'h2402, 32'h01);
    push(32'h2400, 32'h01);
  endtask

  // Slave: ack after a programmable number of wait states, one cycle wide.
  initial begin : slave
    int wcnt;
    wcnt   = 0;
    wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        wb_ack = 1'b0;
      end else if (wb_cyc && wb_stb && slave_en) begin
        if (wcnt == 0) begin
          wb_ack = 1'b1;
          wcnt   = (ack_max == 0) ? 0 : int'($urandom_range(0, ack_max));
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted write, checks hold and gap.
  initial begin : monitor
    logic        prev_stb;
    logic [31:0] pa, pd;
    logic [3:0]  ps;
    logic        gap_chk;
    logic [63:0] e;
    prev_stb = 1'b0;
    gap_chk  = 1'b0;
    pa = '0; pd = '0; ps = '0;
    forever begin
      @(negedge clk); #1;
      if (gap_chk) begin
        check("gap_cyc_low", {95'd0, wb_cyc}, 96'd0);
        gap_chk = 1'b0;
      end
      if (wb_stb && prev_stb)
        check("stb_hold", {28'd0, wb_adr, wb_dat_w, wb_sel}, {28'd0, pa, pd, ps});
      if (wb_stb && !prev_stb && wr_idx < 32)
        t_rise[wr_idx] = $time;
      if (wb_cyc && wb_stb && wb_ack) begin
        if (wr_idx < 32) t_ack[wr_idx] = $time;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, required none", wb_adr, wb_dat_w);
        end else begin
          e = exp_q.pop_front();
          check("wr_adr", {64'd0, wb_adr}, {64'd0, e[63:32]});
          check("wr_dat", {64'd0, wb_dat_w}, {64'd0, e[31:0]});
          check("wr_sel", {92'd0, wb_sel}, {92'd0, 4'hF});
          check("wr_we", {95'd0, wb_we}, 96'd1);
        end
        wr_idx++;
        gap_chk = 1'b1;
      end
      prev_stb = wb_stb;
      pa = wb_adr;
      pd = wb_dat_w;
      ps = wb_sel;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    check("busy_before_start", {95'd0, busy}, 96'd0);
    start   = 1'b1;
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", {95'd0, busy}, 96'd1);
    check("done_cleared", {95'd0, done}, 96'd0);
  endtask

  task automatic run_sequence(input bit poke);
    int n;
    push_sequence();
    pulse_start();
    if (poke) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_reached", {95'd0, done}, 96'd1);
    check("busy_after_done", {95'd0, busy}, 96'd0);
    check("error_low", {95'd0, error}, 96'd0);
    check("write_count", 96'(wr_idx), 96'd31);
    check("queue_empty", 96'(exp_q.size()), 96'd0);
    check("first_cyc_latency", 96'((t_rise[0] - t_start) / 10), 96'd36);
    check("dllk_wait", 96'((t_rise[26] - t_ack[25]) / 10), 96'd602);
    check("zqinit_wait", 96'((t_rise[30] - t_ack[29]) / 10), 96'd602);
  endtask

  initial begin : main
    int  n;
    bit  saw;
    bit  found;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {95'd0, busy}, 96'd0);
    check("rst_done", {95'd0, done}, 96'd0);
    check("rst_error", {95'd0, error}, 96'd0);
    check("rst_bus_ctl", {93'd0, wb_cyc, wb_stb, wb_we}, 96'd0);
    check("rst_sel", {92'd0, wb_sel}, 96'd0);
    check("rst_adr_dat", {32'd0, wb_adr, wb_dat_w}, 96'd0);
    @(negedge clk);
    rst = 1'b0;

    saw = 1'b0;
    repeat (1000) begin
      @(negedge clk); #1;
      if (wb_cyc || busy || done || error) saw = 1'b1;
    end
    check("idle_quiet", {95'd0, saw}, 96'd0);

    ack_max = 0;
    run_sequence(1'b0);

    ack_max = 7;
    run_sequence(1'b1);

    // Asynchronous reset in the middle of the MR1 ADDRESS write.
    push_sequence();
    pulse_start();
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      @(negedge clk); #1;
      if (wb_stb && wb_adr == 32'h2403 && wb_dat_w == 32'h006) found = 1'b1;
      n++;
    end
    check("mr1_reached", {95'd0, found}, 96'd1);
    rst = 1'b1;
    #1;
    check("async_rst_cyc_stb", {94'd0, wb_cyc, wb_stb}, 96'd0);
    check("async_rst_adr", {64'd0, wb_adr}, 96'd0);
    check("async_rst_busy", {95'd0, busy}, 96'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_sequence(1'b0);

`ifdef DFII_INIT_ACK_TIMEOUT_EN
    begin
      time t_err;
      slave_en = 1'b0;
      exp_q.delete();
      wr_idx = 0;
      pulse_start();
      n = 0;
      while (!error && n < 3000) begin
        @(negedge clk); #1;
        n++;
      end
      t_err = $time;
      check("tmo_error", {95'd0, error}, 96'd1);
      check("tmo_cyc_stb", {94'd0, wb_cyc, wb_stb}, 96'd0);
      check("tmo_busy_done", {94'd0, busy, done}, 96'd0);
      check("tmo_issue_cycles", 96'((t_err - t_rise[0]) / 10), 96'd1023);
      check("tmo_no_writes", 96'(wr_idx), 96'd0);
      slave_en = 1'b1;
      run_sequence(1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
